chip_top_wrapper: RTL and testbench
===================================

Name: chip_top_wrapper

Overview:
- IEEE 1149.1-style JTAG test access port wrapping the chip top.
- Contains the 16-state TAP controller, a 4-bit instruction register, and three data registers: BYPASS, IDCODE and an 8-bit USER register whose updated value drives the core.
- The only chip-level access is through TCK/TMS/TDI/TDO, plus the asynchronous test reset.

Parameters:
- IR_W, 4, instruction register width.
- IDCODE_VALUE, 32'h1000_563D, device ID returned by IDCODE. Bit 0 must be 1.
- USER_W, 8, USER data register width.

Ports:
- TCK  input  1  test clock; the only clock.
- TRST_N  input  1  test reset; asynchronous, active-low.
- TMS  input  1  mode select, sampled on TCK rising edge.
- TDI  input  1  serial data in, sampled on TCK rising edge.
- TDO  output  1  serial data out, changes on TCK falling edge.
- USER_OUT  output  USER_W  parallel output of the USER update latch, to the core.

Behaviour:
- Reset (TRST_N=0, asynchronous):
  - TAP state = Test-Logic-Reset (TLR).
  - IR = IDCODE (4'b0001).
  - USER_OUT = 0, TDO = 0, all shift registers = 0.
- Synchronous reset: TMS=1 for 5 consecutive TCK rising edges reaches TLR from any state, with the same register effects as TRST_N.
- TAP FSM states: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauIR, Ex2IR, UpdIR.
- TAP transitions, written as (TMS=0 / TMS=1):
  - TLR → RTI / TLR
  - RTI → RTI / SelDR
  - SelDR → CapDR / SelIR
  - SelIR → CapIR / TLR
  - CapX → ShX / Ex1X
  - ShX → ShX / Ex1X
  - Ex1X → PauX / UpdX
  - PauX → PauX / Ex2X
  - Ex2X → ShX / UpdX
  - UpdX → RTI / SelDR
- State register updates on TCK rising edge.
- Instructions: 0000 EXTEST→BYPASS, 0001 IDCODE, 1011 USER, 1111 BYPASS. Every other opcode selects BYPASS.
- All capture, shift and update actions happen on the TCK rising edge while the FSM is in the named state:
  - CapIR: IR shift register loads 4'b0101.
  - CapDR: selected DR loads its capture value. BYPASS captures 0; IDCODE captures IDCODE_VALUE; USER captures current USER_OUT.
  - ShIR / ShDR: selected shift register shifts right (new = {TDI, sr[N-1:1]}). The edge that leaves ShX also performs a shift, since TDI is sampled in ShX.
  - UpdIR: IR shift contents are copied into the active IR.
  - UpdDR with USER selected: USER shift contents are copied into USER_OUT. No other DR has an update stage.
- TDO:
  - On each TCK falling edge, TDO = sr[0] of the selected chain (IR chain in ShIR, DR chain in ShDR).
  - Otherwise TDO is driven to 0. There is no tristate.
- Latency:
  - BYPASS: TDI appears on TDO 1 shift cycle later.
  - IDCODE: the first TDO bit after CapDR is IDCODE_VALUE[0] (LSB first).
- Pause states hold all shift contents.
- An IR change takes effect only at UpdIR; the new instruction's DR is used from the next CapDR.
- TRST_N assertion mid-shift aborts immediately. No partial update reaches IR or USER_OUT.

Decomposition:
- Package chip_jtag_pkg:
  - TAP state enum (4-bit encoding).
  - Opcode constants: EXTEST, IDCODE, USER, BYPASS.
  - IR_CAPTURE = 4'b0101.
- Sub-module jtag_tap_fsm:
  - Inputs: TCK, TRST_N, TMS.
  - Outputs: state plus one-hot decodes (capture_dr, shift_dr, update_dr, capture_ir, shift_ir, update_ir, tlr).
- The top level holds the IR, DRs, DR mux and the falling-edge TDO flop.

Test Plan:
1. Reset and TLR:
   - Pulse TRST_N low in ShDR → state TLR, TDO=0, USER_OUT=0, IR=0001.
   - From RTI, TMS=1 for 5 edges → TLR.
2. IDCODE after reset:
   - TMS 0,1,0,0 (to ShDR), then 32 shift edges → TDO serial LSB first = 32'h1000_563D (first bit 1).
3. IR capture and BYPASS:
   - Enter ShIR, shift TDI=1,1,1,1 → TDO=1,0,1,0.
   - Exit via UpdIR → IR=1111.
   - DR shift of TDI 1,0,1,1 → TDO 0,1,0,1 (1-cycle delay).
4. USER write/readback:
   - Load IR with TDI 1,1,0,1 (=1011).
   - DR shift 8 bits of 0xA5 LSB first, then UpdDR → USER_OUT=0xA5.
   - Next CapDR/ShDR → TDO emits 1,0,1,0,0,1,0,1.
5. Illegal opcode and pause:
   - IR=0110 → BYPASS behaviour.
   - Enter PauDR for 3 cycles mid-USER shift → contents preserved, TDO=0 during pause, shift resumes correctly via Ex2DR.
6. Reset mid-update:
   - TRST_N low during ShDR of USER after 4 bits → USER_OUT stays 0, IR returns 0001.

Source files
------------

// File: rtl/chip_jtag_pkg.sv
// rtl/chip_jtag_pkg.sv - JTAG TAP state encoding, opcodes and DR selection
package chip_jtag_pkg;

    typedef enum logic [3:0] {
        TAP_TLR,
        TAP_RTI,
        TAP_SEL_DR,
        TAP_CAP_DR,
        TAP_SH_DR,
        TAP_EX1_DR,
        TAP_PAU_DR,
        TAP_EX2_DR,
        TAP_UPD_DR,
        TAP_SEL_IR,
        TAP_CAP_IR,
        TAP_SH_IR,
        TAP_EX1_IR,
        TAP_PAU_IR,
        TAP_EX2_IR,
        TAP_UPD_IR
    } tap_state_e;

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_USER
    } dr_sel_e;

    localparam logic [3:0] OP_EXTEST  = 4'b0000;
    localparam logic [3:0] OP_IDCODE  = 4'b0001;
    localparam logic [3:0] OP_USER    = 4'b1011;
    localparam logic [3:0] OP_BYPASS  = 4'b1111;
    localparam logic [3:0] IR_CAPTURE = 4'b0101;

    // EXTEST and every unassigned opcode fall through to BYPASS
    function automatic dr_sel_e dr_select(input logic [3:0] op);
        case (op)
            OP_IDCODE: return DR_IDCODE;
            OP_USER:   return DR_USER;
            default:   return DR_BYPASS;
        endcase
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// rtl/jtag_tap_fsm.sv - 16-state IEEE 1149.1 TAP controller with state decodes
module jtag_tap_fsm
    import chip_jtag_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST_N,
    input  logic       TMS,
    output tap_state_e state,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr,
    output logic       capture_ir,
    output logic       shift_ir,
    output logic       update_ir,
    output logic       tlr
);

    tap_state_e next_state;

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            state <= TAP_TLR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            TAP_TLR:    next_state = TMS ? TAP_TLR    : TAP_RTI;
            TAP_RTI:    next_state = TMS ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR: next_state = TMS ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR: next_state = TMS ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:  next_state = TMS ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR: next_state = TMS ? TAP_UPD_DR : TAP_PAU_DR;
            TAP_PAU_DR: next_state = TMS ? TAP_EX2_DR : TAP_PAU_DR;
            TAP_EX2_DR: next_state = TMS ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR: next_state = TMS ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR: next_state = TMS ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR: next_state = TMS ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:  next_state = TMS ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR: next_state = TMS ? TAP_UPD_IR : TAP_PAU_IR;
            TAP_PAU_IR: next_state = TMS ? TAP_EX2_IR : TAP_PAU_IR;
            TAP_EX2_IR: next_state = TMS ? TAP_UPD_IR : TAP_SH_IR;
            TAP_UPD_IR: next_state = TMS ? TAP_SEL_DR : TAP_RTI;
            default:    next_state = TAP_TLR;
        endcase
    end

    assign capture_dr = (state == TAP_CAP_DR);
    assign shift_dr   = (state == TAP_SH_DR);
    assign update_dr  = (state == TAP_UPD_DR);
    assign capture_ir = (state == TAP_CAP_IR);
    assign shift_ir   = (state == TAP_SH_IR);
    assign update_ir  = (state == TAP_UPD_IR);
    assign tlr        = (state == TAP_TLR);

endmodule

// File: rtl/chip_top_wrapper.sv
// rtl/chip_top_wrapper.sv - JTAG TAP wrapper with IR, BYPASS, IDCODE and USER registers
module chip_top_wrapper
    import chip_jtag_pkg::*;
#(
    parameter int          IR_W         = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_563D,
    parameter int          USER_W       = 8
) (
    input  logic              TCK,
    input  logic              TRST_N,
    input  logic              TMS,
    input  logic              TDI,
    output logic              TDO,
    output logic [USER_W-1:0] USER_OUT
);

    tap_state_e        tap_state;
    logic              capture_dr, shift_dr, update_dr;
    logic              capture_ir, shift_ir, update_ir;
    logic              tlr;

    logic [IR_W-1:0]   ir_sr;
    logic [IR_W-1:0]   ir;
    logic              bypass_sr;
    logic [31:0]       id_sr;
    logic [USER_W-1:0] user_sr;
    dr_sel_e           dr_sel;
    logic              dr_tdo;

    jtag_tap_fsm u_tap (
        .TCK        (TCK),
        .TRST_N     (TRST_N),
        .TMS        (TMS),
        .state      (tap_state),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir),
        .tlr        (tlr)
    );

    // Selection follows the active IR only, so an IR scan cannot disturb a DR path mid-flight
    assign dr_sel = dr_select(ir);

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            ir_sr     <= '0;
            ir        <= IR_W'(OP_IDCODE);
            bypass_sr <= 1'b0;
            id_sr     <= '0;
            user_sr   <= '0;
            USER_OUT  <= '0;
        end else if (tlr) begin
            ir_sr     <= '0;
            ir        <= IR_W'(OP_IDCODE);
            bypass_sr <= 1'b0;
            id_sr     <= '0;
            user_sr   <= '0;
            USER_OUT  <= '0;
        end else begin
            if (capture_ir) begin
                ir_sr <= IR_W'(IR_CAPTURE);
            end else if (shift_ir) begin
                ir_sr <= {TDI, ir_sr[IR_W-1:1]};
            end
            if (update_ir) begin
                ir <= ir_sr;
            end

            if (capture_dr) begin
                case (dr_sel)
                    DR_IDCODE: id_sr     <= IDCODE_VALUE;
                    DR_USER:   user_sr   <= USER_OUT;
                    default:   bypass_sr <= 1'b0;
                endcase
            end else if (shift_dr) begin
                case (dr_sel)
                    DR_IDCODE: id_sr     <= {TDI, id_sr[31:1]};
                    DR_USER:   user_sr   <= {TDI, user_sr[USER_W-1:1]};
                    default:   bypass_sr <= TDI;
                endcase
            end
            if (update_dr && dr_sel == DR_USER) begin
                USER_OUT <= user_sr;
            end
        end
    end

    always_comb begin
        dr_tdo = bypass_sr;
        case (dr_sel)
            DR_IDCODE: dr_tdo = id_sr[0];
            DR_USER:   dr_tdo = user_sr[0];
            default:   dr_tdo = bypass_sr;
        endcase
    end

    // Falling-edge launch gives the remote end half a TCK of setup before its rising-edge sample
    always_ff @(negedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            TDO <= 1'b0;
        end else begin
            case (tap_state)
                TAP_SH_IR: TDO <= ir_sr[0];
                TAP_SH_DR: TDO <= dr_tdo;
                default:   TDO <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_chip_top_wrapper.sv
// tb/tb_chip_top_wrapper.sv - self-checking bench for chip_top_wrapper
module tb_chip_top_wrapper;
    import chip_jtag_pkg::*;

    localparam logic [31:0] IDV = 32'h1000_563D;

    logic       TCK = 1'b0;
    logic       TRST_N = 1'b0;
    logic       TMS = 1'b1;
    logic       TDI = 1'b0;
    logic       TDO;
    logic [7:0] USER_OUT;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] m_ir;
    logic [7:0] m_user;

    chip_top_wrapper #(.IR_W(4), .IDCODE_VALUE(IDV), .USER_W(8)) dut (
        .TCK      (TCK),
        .TRST_N   (TRST_N),
        .TMS      (TMS),
        .TDI      (TDI),
        .TDO      (TDO),
        .USER_OUT (USER_OUT)
    );

    always #5 TCK = ~TCK;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        @(negedge TCK);
        #1;
    endtask

    task automatic model_reset();
        m_ir   = 4'b0001;
        m_user = 8'h00;
    endtask

    // Chain modelled as a FIFO: bit leaving on TDO pops the front, TDI pushes the back
    task automatic model_scan(input bit is_ir, input int n, input logic [63:0] din,
                              output logic [63:0] dout);
        bit          q[$];
        logic [63:0] cap;
        logic [63:0] v;
        int          len;
        if (is_ir) begin
            cap = 64'h5; len = 4;
        end else if (m_ir == 4'b0001) begin
            cap = {32'h0, IDV}; len = 32;
        end else if (m_ir == 4'b1011) begin
            cap = {56'h0, m_user}; len = 8;
        end else begin
            cap = 64'h0; len = 1;
        end
        for (int i = 0; i < len; i++) q.push_back(cap[i]);
        dout = '0;
        for (int i = 0; i < n; i++) begin
            dout[i] = q.pop_front();
            q.push_back(din[i]);
        end
        v = '0;
        for (int i = 0; i < len; i++) v[i] = q[i];
        if (is_ir) m_ir = v[3:0];
        else if (m_ir == 4'b1011) m_user = v[7:0];
    endtask

    // From RTI: scan n bits, optionally pausing 3 cycles after bit pause_at, end in RTI
    task automatic scan(input bit is_ir, input int n, input logic [63:0] din,
                        input int pause_at, output logic [63:0] dout);
        bit last;
        step(1'b1, 1'b0);
        if (is_ir) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        dout = '0;
        for (int i = 0; i < n; i++) begin
            dout[i] = TDO;
            last = (i == n - 1) || (i == pause_at - 1);
            step(last, din[i]);
            if (i == pause_at - 1 && i != n - 1) begin
                for (int k = 0; k < 3; k++) begin
                    step(1'b0, 1'b0);
                    check("tdo_pause", 64'(TDO), 64'h0);
                end
                step(1'b1, 1'b0);
                step(1'b0, 1'b0);
            end
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic do_scan(input string tag, input bit is_ir, input int n,
                           input logic [63:0] din, input int pause_at);
        logic [63:0] got, exp, mask;
        model_scan(is_ir, n, din, exp);
        scan(is_ir, n, din, pause_at, got);
        mask = (n >= 64) ? '1 : ((64'h1 << n) - 64'h1);
        check(tag, got & mask, exp & mask);
        if (is_ir) check({tag, "_ir"}, 64'(dut.ir), 64'(m_ir));
        else check({tag, "_user"}, 64'(USER_OUT), 64'(m_user));
    endtask

    task automatic async_reset_checks(input string tag);
        TRST_N = 1'b0;
        #1;
        model_reset();
        check({tag, "_state"}, 64'(dut.u_tap.state), 64'(TAP_TLR));
        check({tag, "_tdo"}, 64'(TDO), 64'h0);
        check({tag, "_user"}, 64'(USER_OUT), 64'(m_user));
        check({tag, "_ir"}, 64'(dut.ir), 64'(m_ir));
        TRST_N = 1'b1;
        #1;
        step(1'b0, 1'b0);
    endtask

    initial begin
        logic [63:0] r;
        logic [3:0]  op;
        int          n, pa;
        model_reset();
        #12 TRST_N = 1'b1;
        @(negedge TCK);
        #1;
        check("rst_state", 64'(dut.u_tap.state), 64'(TAP_TLR));
        check("rst_ir", 64'(dut.ir), 64'h1);
        check("rst_user", 64'(USER_OUT), 64'h0);
        check("rst_tdo", 64'(TDO), 64'h0);
        step(1'b0, 1'b0);

        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("shdr_state", 64'(dut.u_tap.state), 64'(TAP_SH_DR));
        check("shdr_tdo_first", 64'(TDO), 64'(IDV[0]));
        async_reset_checks("trst_shdr");

        do_scan("ir_bypass", 1'b1, 4, 64'hF, 0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
        model_reset();
        check("sync_rst_state", 64'(dut.u_tap.state), 64'(TAP_TLR));
        check("sync_rst_ir", 64'(dut.ir), 64'(m_ir));
        step(1'b0, 1'b0);

        do_scan("idcode", 1'b0, 32, {$urandom, $urandom}, 0);

        do_scan("ir_1111", 1'b1, 4, 64'hF, 0);
        do_scan("bypass_1011", 1'b0, 4, 64'hD, 0);

        do_scan("ir_user", 1'b1, 4, 64'hB, 0);
        do_scan("user_a5", 1'b0, 8, 64'hA5, 0);
        check("user_out_a5", 64'(USER_OUT), 64'hA5);
        do_scan("user_readback", 1'b0, 8, {$urandom, $urandom}, 0);

        do_scan("ir_0110", 1'b1, 4, 64'h6, 0);
        do_scan("bypass_0110", 1'b0, 10, {$urandom, $urandom}, 0);
        do_scan("ir_user2", 1'b1, 4, 64'hB, 0);
        do_scan("user_pause", 1'b0, 8, {$urandom, $urandom}, 3);
        do_scan("user_pause_rb", 1'b0, 8, {$urandom, $urandom}, 5);

        async_reset_checks("pre_partial");
        do_scan("ir_user3", 1'b1, 4, 64'hB, 0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1);
        async_reset_checks("trst_partial");

        for (int it = 0; it < 20; it++) begin
            case ($urandom_range(0, 3))
                0: op = 4'b0001;
                1: op = 4'b1011;
                2: op = 4'b1111;
                default: op = 4'($urandom);
            endcase
            do_scan("rnd_ir", 1'b1, 4, 64'(op), 0);
            n  = $urandom_range(1, 40);
            pa = (n > 2 && $urandom_range(0, 1) == 1) ? $urandom_range(1, n - 1) : 0;
            r  = {$urandom, $urandom};
            do_scan("rnd_dr", 1'b0, n, r, pa);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
